mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Arbitrates the single shared main memory (memory4c) between the I-cache and D-cache miss FSMs.
//  Grants one requester at a time and holds the grant for its whole fill/write burst.
//  Keeps the grant until every read in flight has returned, and steers mem_data_valid to the owner.
//  Sits in cpu between both Cache instances and Main_Mem, replacing the ad-hoc mem_access_* muxing.
// PARAMETERS
//  MEM_LAT  4   memory4c read latency in cycles (issue -> data_valid); also the max reads in flight
//  ADDR_W   16  address width
//  DATA_W   16  write-data width
// PORTS
//  clk             in   1       single clock, rising edge
//  rst             in   1       asynchronous, active-high reset
//  i_req           in   1       I-cache miss FSM request (level, held for whole burst)
//  i_addr          in   ADDR_W  I-cache miss address (valid while i_gnt)
//  i_gnt           out  1       I-cache owns memory
//  i_data_valid    out  1       mem_data_valid steered to I-cache
//  d_req           in   1       D-cache request (level, held for whole burst)
//  d_wr            in   1       D-cache access is a write
//  d_addr          in   ADDR_W  D-cache address
//  d_wdata         in   DATA_W  D-cache write data
//  d_gnt           out  1       D-cache owns memory
//  d_data_valid    out  1       mem_data_valid steered to D-cache
//  mem_en          out  1       memory4c enable
//  mem_wr          out  1       memory4c write
//  mem_addr        out  ADDR_W  memory4c address
//  mem_wdata       out  DATA_W  memory4c data_in
//  mem_data_valid  in   1       memory4c data_valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, outstanding count 0, last_owner = I. Reset takes effect immediately, including mid-burst.
//  States: IDLE, GNT_I, GNT_D, DRAIN_I, DRAIN_D. Grants are registered (Moore).
//  IDLE: d_req & ~i_req -> GNT_D. i_req & ~d_req -> GNT_I.
//    Both requesting -> D wins, unless last_owner == D, in which case I wins. This prevents starvation.
//  GNT_x: x_gnt = 1.
//    mem_en = x_req. mem_addr comes from x. mem_wr = d_wr for D and 0 for I. mem_wdata = d_wdata for D and 0 for I.
//    x_req dropping -> DRAIN_x if outstanding != 0, else IDLE. On that transition, last_owner <= x.
//  DRAIN_x: x_gnt = 1, mem_en = 0. Go to IDLE in the cycle after outstanding reaches 0.
//    If x re-raises req in DRAIN_x, it is ignored until IDLE and then re-arbitrated.
//  Latency: req rises at cycle N in IDLE -> gnt at N+1 -> first mem access at N+1.
//    Read data_valid then arrives at N+1+MEM_LAT.
//  When neither cache has a grant, all mem_* outputs are 0.
//  Outstanding counter (width $clog2(MEM_LAT+1)):
//    +1 on a read issue (mem_en & ~mem_wr); -1 on mem_data_valid; unchanged when both happen in the same cycle.
//    Writes are not counted (memory4c completes a write in the issue cycle).
//    Saturates at MEM_LAT. A read issue while already at MEM_LAT is a protocol error and fires an assertion.
//  Valid steering: x_data_valid = mem_data_valid & x_gnt & (outstanding != 0).
//    A data_valid with outstanding == 0 (e.g. a stray return after reset) is dropped and asserts neither output.
//  i_gnt and d_gnt are never both 1. The grant never changes while outstanding != 0.
//  No combinational path from mem_data_valid to any grant.
// STRUCTURE
//  Add to cpu.vh: state encodings (`ARB_IDLE, `ARB_GNT_I, `ARB_GNT_D, `ARB_DRN_I, `ARB_DRN_D)
//    and owner codes (`OWN_I = 1'b0, `OWN_D = 1'b1).
//  One sub-module: arb_outstanding_ctr. It holds the up/down saturating counter with inc, dec and zero flag.
//  The FSM and output muxing live in mem_arbiter. cpu drives Main_Mem only from mem_arbiter outputs.
//  A model of memory4c with a MEM_LAT-deep pipeline is used in the bench.
// TESTING
//  1. Lone I fill: i_req from cycle 0, held for 8 reads at 0x0100..0x010E, then dropped.
//     -> i_gnt at cycle 1; 8 i_data_valid pulses starting at cycle 5; DRAIN_I until the last valid; IDLE after.
//  2. Simultaneous i_req and d_req from reset.
//     -> d_gnt first. After D completes and drains, i_gnt with no idle cycle beyond the IDLE hop.
//     -> When both are then re-requested, I wins (last_owner = D).
//  3. D write burst (d_wr = 1, addr 0x2000, data 0xBEEF, 4 writes).
//     -> mem_wr = 1 and mem_wdata = 0xBEEF while d_gnt; outstanding stays 0; IDLE the cycle after d_req drops.
//  4. i_req drops with 3 reads in flight while d_req is high.
//     -> d_gnt stays 0 until the 3rd i_data_valid; d_data_valid never pulses for I data.
//  5. rst asserted mid-fill with 2 reads outstanding.
//     -> all outputs 0 at once. The 2 late mem_data_valid pulses are dropped (no x_data_valid).
//  6. Random req/wr traffic for 10k cycles, checked against a scoreboard.
//     -> never both grants; each valid reaches its issuer; no starvation beyond 2 bursts.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Package     : mem_arbiter_pkg
// Description : State and owner encodings shared by the memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_arbiter_pkg;

    localparam logic [2:0] c_ARB_IDLE  = 3'd0;
    localparam logic [2:0] c_ARB_GNT_I = 3'd1;
    localparam logic [2:0] c_ARB_GNT_D = 3'd2;
    localparam logic [2:0] c_ARB_DRN_I = 3'd3;
    localparam logic [2:0] c_ARB_DRN_D = 3'd4;

    localparam logic c_OWN_I = 1'b0;
    localparam logic c_OWN_D = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ARB_IDLE,
        ST_GNT_I = c_ARB_GNT_I,
        ST_GNT_D = c_ARB_GNT_D,
        ST_DRN_I = c_ARB_DRN_I,
        ST_DRN_D = c_ARB_DRN_D
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/arb_outstanding_ctr.sv
// ============================================================================
// Module      : arb_outstanding_ctr
// Description : Saturating up/down count of memory reads still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module arb_outstanding_ctr #(
    parameter int MAX = 4,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic zero
);

    localparam logic [W-1:0] c_MAX = W'(MAX);

    logic [W-1:0] r_count;

    // A simultaneous issue and return leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && !dec) begin
            if (r_count != c_MAX) begin
                r_count <= r_count + W'(1);
            end
        end else if (dec && !inc && r_count != '0) begin
            r_count <= r_count - W'(1);
        end
    end

    assign zero = (r_count == '0);

    always @(posedge clk) begin
        if (!rst && inc && !dec) begin
            a_no_overflow: assert (r_count != c_MAX);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module      : mem_arbiter
// Description : Grants the shared memory to the I-cache or D-cache for a whole
//               burst and steers read-data valid back to the owner.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
    parameter int MEM_LAT = 4,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_data_valid,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_data_valid,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_data_valid
);

    import mem_arbiter_pkg::*;

    localparam int c_CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t r_state;
    logic       r_last_owner;
    logic       r_i_gnt;
    logic       r_d_gnt;
    logic       w_zero;
    logic       w_inc;
    logic       w_dec;

    // Stray returns with nothing in flight must not disturb the count.
    assign w_inc = mem_en && !mem_wr;
    assign w_dec = mem_data_valid && !w_zero;

    arb_outstanding_ctr #(
        .MAX (MEM_LAT),
        .W   (c_CNT_W)
    ) u_outstanding (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_inc),
        .dec  (w_dec),
        .zero (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_owner <= c_OWN_I;
            r_i_gnt      <= 1'b0;
            r_d_gnt      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie D wins unless it owned the memory last.
                    if (d_req && (!i_req || r_last_owner == c_OWN_I)) begin
                        r_state <= ST_GNT_D;
                        r_d_gnt <= 1'b1;
                    end else if (i_req) begin
                        r_state <= ST_GNT_I;
                        r_i_gnt <= 1'b1;
                    end
                end
                ST_GNT_I: begin
                    if (!i_req) begin
                        r_last_owner <= c_OWN_I;
                        if (w_zero) begin
                            r_state <= ST_IDLE;
                            r_i_gnt <= 1'b0;
                        end else begin
                            r_state <= ST_DRN_I;
                        end
                    end
                end
                ST_GNT_D: begin
                    if (!d_req) begin
                        r_last_owner <= c_OWN_D;
                        if (w_zero) begin
                            r_state <= ST_IDLE;
                            r_d_gnt <= 1'b0;
                        end else begin
                            r_state <= ST_DRN_D;
                        end
                    end
                end
                ST_DRN_I: begin
                    if (w_zero) begin
                        r_state <= ST_IDLE;
                        r_i_gnt <= 1'b0;
                    end
                end
                ST_DRN_D: begin
                    if (w_zero) begin
                        r_state <= ST_IDLE;
                        r_d_gnt <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_i_gnt <= 1'b0;
                    r_d_gnt <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_GNT_I: begin
                mem_en   = i_req;
                mem_addr = i_addr;
            end
            ST_GNT_D: begin
                mem_en    = d_req;
                mem_wr    = d_wr;
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
            end
            default: begin
            end
        endcase
    end

    assign i_gnt        = r_i_gnt;
    assign d_gnt        = r_d_gnt;
    assign i_data_valid = mem_data_valid && r_i_gnt && !w_zero;
    assign d_data_valid = mem_data_valid && r_d_gnt && !w_zero;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed and random checks of mem_arbiter against a
//               burst-level ownership model and a tagged memory pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;

    localparam int MEM_LAT = 4;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic              i_gnt;
    logic              i_data_valid;
    logic              d_req = 1'b0;
    logic              d_wr = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_gnt;
    logic              d_data_valid;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_data_valid = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .MEM_LAT (MEM_LAT),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_data_valid   (i_data_valid),
        .d_req          (d_req),
        .d_wr           (d_wr),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_data_valid   (d_data_valid),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_data_valid (mem_data_valid)
    );

    int errors = 0;
    int checks = 0;
    int t      = 0;
    int t0     = 0;

    // Ownership model: 0 none, 1 I, 2 D; rel = owner has let go, waiting for returns.
    int own    = 0;
    bit rel    = 1'b0;
    bit last_d = 1'b0;

    // Memory pipeline: each read returns MEM_LAT cycles after issue, tagged with issuer (3 = pre-reset stray).
    typedef struct {
        int ret;
        int tag;
    } rd_t;
    rd_t pipe[$];

    int          i_left = 0, d_left = 0, i_done = 0, d_done = 0;
    logic [15:0] i_base = '0, d_base = '0;

    int ig_rise[$], dg_rise[$], ig_fall[$], dg_fall[$], idv_t[$], ddv_t[$];
    int wr_beef = 0;
    bit prev_ig = 1'b0, prev_dg = 1'b0;
    int wait_i  = 0, wait_d = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, t - t0);
        end
    endtask

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    task automatic start_i(input int len, input logic [15:0] base);
        i_left = len;
        i_done = 0;
        i_base = base;
    endtask

    task automatic start_d(input int len, input logic [15:0] base);
        d_left = len;
        d_done = 0;
        d_base = base;
    endtask

    task automatic clr_mon();
        ig_rise.delete(); dg_rise.delete(); ig_fall.delete(); dg_fall.delete();
        idv_t.delete(); ddv_t.delete();
        wr_beef = 0;
        t0 = t;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later, advance the model.
    task automatic step();
        bit          dv;
        int          tag, infl;
        logic        exp_ig, exp_dg, exp_en, exp_wr;
        logic [15:0] exp_addr, exp_wd;
        i_req  = (i_left > 0);
        d_req  = (d_left > 0);
        i_addr = i_base + 16'(2 * i_done);
        d_addr = d_base + 16'(2 * d_done);
        if (rst) begin
            own = 0; rel = 1'b0; last_d = 1'b0;
            foreach (pipe[k]) pipe[k].tag = 3;
        end
        dv  = 1'b0;
        tag = 0;
        if (pipe.size() > 0 && pipe[0].ret == t) begin
            dv  = 1'b1;
            tag = pipe[0].tag;
        end
        infl = 0;
        foreach (pipe[k]) if (pipe[k].tag != 3) infl++;
        mem_data_valid = dv;
        #1;
        exp_ig   = (own == 1);
        exp_dg   = (own == 2);
        exp_en   = !rel && ((own == 1 && i_req) || (own == 2 && d_req));
        exp_wr   = (!rel && own == 2) ? d_wr : 1'b0;
        exp_addr = (!rel && own == 1) ? i_addr : (!rel && own == 2) ? d_addr : 16'h0;
        exp_wd   = (!rel && own == 2) ? d_wdata : 16'h0;
        chk("i_gnt", i_gnt, exp_ig);
        chk("d_gnt", d_gnt, exp_dg);
        chk("one_grant", i_gnt & d_gnt, 0);
        chk("mem_en", mem_en, exp_en);
        chk("mem_wr", mem_wr, exp_wr);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wd);
        chk("i_data_valid", i_data_valid, dv && tag == 1);
        chk("d_data_valid", d_data_valid, dv && tag == 2);

        if (i_gnt && !prev_ig) begin
            ig_rise.push_back(t - t0);
            wait_i = 0;
            if (d_req) begin
                wait_d++;
                chk("no_starve_d", wait_d <= 2, 1);
            end
        end
        if (d_gnt && !prev_dg) begin
            dg_rise.push_back(t - t0);
            wait_d = 0;
            if (i_req) begin
                wait_i++;
                chk("no_starve_i", wait_i <= 2, 1);
            end
        end
        if (!i_gnt && prev_ig) ig_fall.push_back(t - t0);
        if (!d_gnt && prev_dg) dg_fall.push_back(t - t0);
        prev_ig = i_gnt;
        prev_dg = d_gnt;
        if (i_data_valid) idv_t.push_back(t - t0);
        if (d_data_valid) ddv_t.push_back(t - t0);
        if (d_gnt && mem_en && mem_wr && mem_wdata == 16'hBEEF) wr_beef++;

        if (dv) void'(pipe.pop_front());
        if (mem_en && !mem_wr) pipe.push_back('{ret: t + MEM_LAT, tag: own});

        if (exp_en && own == 1) begin i_done++; i_left--; end
        if (exp_en && own == 2) begin d_done++; d_left--; end

        if (!rst) begin
            if (own == 0) begin
                if (i_req && d_req) own = last_d ? 1 : 2;
                else if (d_req)     own = 2;
                else if (i_req)     own = 1;
            end else if (!rel) begin
                if (!((own == 1) ? i_req : d_req)) begin
                    last_d = (own == 2);
                    if (infl == 0) own = 0;
                    else           rel = 1'b1;
                end
            end else if (infl == 0) begin
                own = 0;
                rel = 1'b0;
            end
        end
        t++;
        @(negedge clk);
    endtask

    task automatic run_idle(input int bound);
        int n = 0;
        while (!(own == 0 && i_left == 0 && d_left == 0) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $error("FAIL run_idle_timeout: observed busy after %0d cycles, expected idle", bound);
        end
        repeat (2) step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;

        // Lone I fill of 8 reads.
        clr_mon();
        start_i(8, 16'h0100);
        run_idle(60);
        chk("t1_gnt_cycle", at(ig_rise, 0), 1);
        chk("t1_first_valid", at(idv_t, 0), 5);
        chk("t1_valid_count", idv_t.size(), 8);
        chk("t1_last_valid", at(idv_t, 7), 12);
        chk("t1_gnt_drop", at(ig_fall, 0), 14);

        // Simultaneous requests from reset; D re-requests during its drain.
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_mon();
        start_i(4, 16'h0300);
        start_d(4, 16'h0400);
        n = 0;
        while (!(own == 2 && rel) && n < 40) begin step(); n++; end
        start_d(3, 16'h0500);
        run_idle(80);
        chk("t2_d_first", at(dg_rise, 0), 1);
        chk("t2_d_drop", at(dg_fall, 0), 10);
        chk("t2_i_next", at(ig_rise, 0), 11);
        chk("t2_d_second", at(dg_rise, 1), 21);

        // D write burst.
        clr_mon();
        d_wr    = 1'b1;
        d_wdata = 16'hBEEF;
        start_d(4, 16'h2000);
        run_idle(40);
        chk("t3_gnt_cycle", at(dg_rise, 0), 1);
        chk("t3_gnt_drop", at(dg_fall, 0), 6);
        chk("t3_write_count", wr_beef, 4);
        chk("t3_no_valid", ddv_t.size(), 0);
        d_wr = 1'b0;

        // I releases with 3 reads in flight while D waits.
        clr_mon();
        start_i(3, 16'h0600);
        repeat (2) step();
        start_d(2, 16'h0700);
        run_idle(60);
        chk("t4_i_valids", idv_t.size(), 3);
        chk("t4_last_i_valid", at(idv_t, 2), 7);
        chk("t4_d_gnt", at(dg_rise, 0), 10);
        chk("t4_d_valids", ddv_t.size(), 2);
        chk("t4_first_d_valid", at(ddv_t, 0), 14);

        // Reset mid-fill with 2 reads outstanding.
        clr_mon();
        start_i(8, 16'h0800);
        repeat (3) step();
        rst    = 1'b1;
        i_left = 0;
        step();
        chk("t5_rst_gnt", i_gnt, 0);
        chk("t5_rst_en", mem_en, 0);
        rst = 1'b0;
        repeat (8) step();
        chk("t5_i_valids", idv_t.size(), 2'd0);
        chk("t5_d_valids", ddv_t.size(), 0);

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            if (i_left == 0 && !i_req && $urandom_range(0, 7) == 0)
                start_i($urandom_range(1, 8), 16'($urandom));
            if (d_left == 0 && !d_req && $urandom_range(0, 7) == 0) begin
                d_wr    = 1'($urandom_range(0, 1));
                d_wdata = 16'($urandom);
                start_d($urandom_range(1, 8), 16'($urandom));
            end
            step();
        end
        run_idle(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
